// File: rtl/factorial_core.sv
// factorial_core: bus-programmed engine that computes N! mod 2^128 with a shift-add multiplier.
// Latency: 1 edge for N<2, else 1+65*(N-1) edges from the start write to opdone; reads are combinational from registers.
// Backpressure: none; start/operand/irq-enable writes while busy are dropped, a clear write is always taken.
module factorial_core #(
   parameter int MUL_BITS = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_sel,
   input  logic                s_wr,
   input  logic [2:0]          s_addr,
   input  logic [63:0]         s_wdata,
   output logic [63:0]         q0,
   output logic [63:0]         q1,
   output logic [63:0]         q2,
   output logic [63:0]         q3,
   output logic [63:0]         q4,
   output logic [63:0]         q5,
   output logic [63:0]         q6,
   output logic [63:0]         q7,
   output logic                intr
);

   // Register word indices as seen on the read mux.
   localparam logic [2:0] A_OPSTART  = 3'd0;
   localparam logic [2:0] A_OPCLEAR  = 3'd1;
   localparam logic [2:0] A_INTR_EN  = 3'd2;
   localparam logic [2:0] A_OPERAND  = 3'd3;

   // One multiplier bit is consumed per MUL cycle.
   localparam int              CW       = $clog2(MUL_BITS);
   localparam logic [CW-1:0]   LAST_BIT = CW'(MUL_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_MUL  = 3'd2,
      S_DEC  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                state;

   // Architectural registers.
   logic                  intr_en;
   logic [MUL_BITS-1:0]   operand;
   logic [127:0]          result;
   logic                  opdone;
   logic                  busy;

   // Datapath: running factorial, current multiplier value, partial product.
   logic [127:0]          acc;
   logic [MUL_BITS-1:0]   k;
   logic [127:0]          prod;
   logic [CW-1:0]         bit_idx;

   // Decoded bus strobes and datapath helpers.
   logic                  wr;
   logic                  wr_start;
   logic                  wr_clear;
   logic                  wr_inten;
   logic                  wr_operand;
   logic [127:0]          prod_add;
   logic [MUL_BITS-1:0]   k_m1;
   logic                  k_m1_ge2;
   logic                  operand_lt2;

   // Write decode and shift-add step; the sum wraps at 128 bits by construction.
   always_comb begin
      wr          = s_sel & s_wr;
      wr_start    = wr & (s_addr == A_OPSTART) & s_wdata[0];
      wr_clear    = wr & (s_addr == A_OPCLEAR) & s_wdata[0];
      wr_inten    = wr & (s_addr == A_INTR_EN);
      wr_operand  = wr & (s_addr == A_OPERAND);
      prod_add    = prod + (acc << bit_idx);
      k_m1        = k - MUL_BITS'(1);
      k_m1_ge2    = (k_m1 >= MUL_BITS'(2));
      operand_lt2 = (operand < MUL_BITS'(2));
   end

   // Control FSM with registered status, result and interrupt outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         intr_en <= 1'b0;
         operand <= '0;
         result  <= '0;
         opdone  <= 1'b0;
         busy    <= 1'b0;
         intr    <= 1'b0;
         acc     <= '0;
         k       <= '0;
         prod    <= '0;
         bit_idx <= '0;
      end else if (wr_clear) begin
         // Abort from any state; operand and irq enable are kept.
         state   <= S_IDLE;
         result  <= '0;
         opdone  <= 1'b0;
         busy    <= 1'b0;
         intr    <= 1'b0;
         prod    <= '0;
         bit_idx <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (wr_start) begin
                  state  <= S_INIT;
                  result <= '0;
                  opdone <= 1'b0;
                  busy   <= 1'b1;
                  intr   <= 1'b0;
               end else if (wr_inten) begin
                  intr_en <= s_wdata[0];
                  intr    <= opdone & s_wdata[0];
               end else if (wr_operand) begin
                  operand <= s_wdata[MUL_BITS-1:0];
               end
            end

            S_INIT: begin
               acc     <= 128'd1;
               k       <= operand;
               prod    <= '0;
               bit_idx <= '0;
               if (operand_lt2) begin
                  // 0! and 1! finish here, no multiply needed.
                  state  <= S_DONE;
                  result <= 128'd1;
                  opdone <= 1'b1;
                  busy   <= 1'b0;
                  intr   <= intr_en;
               end else begin
                  state <= S_MUL;
               end
            end

            S_MUL: begin
               if (k[bit_idx]) begin
                  prod <= prod_add;
               end
               bit_idx <= bit_idx + CW'(1);
               if (bit_idx == LAST_BIT) begin
                  state <= S_DEC;
               end
            end

            S_DEC: begin
               acc     <= prod;
               k       <= k_m1;
               prod    <= '0;
               bit_idx <= '0;
               if (k_m1_ge2) begin
                  state <= S_MUL;
               end else begin
                  // Publish the finished product directly from the partial-product register.
                  state  <= S_DONE;
                  result <= prod;
                  opdone <= 1'b1;
                  busy   <= 1'b0;
                  intr   <= intr_en;
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Read-side view of the register map, in word-index order.
   assign q0 = 64'd0;
   assign q1 = 64'd0;
   assign q2 = {63'd0, intr_en};
   assign q3 = 64'(operand);
   assign q4 = result[127:64];
   assign q5 = result[63:0];
   assign q6 = {62'd0, busy, opdone};
   assign q7 = 64'd0;

endmodule

// File: tb/tb_factorial_core.sv
// tb_factorial_core: directed vectors against hand-computed factorials and status values.
// Inputs change at the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_factorial_core;

   logic        clk;
   logic        reset;
   logic        s_sel;
   logic        s_wr;
   logic [2:0]  s_addr;
   logic [63:0] s_wdata;
   logic [63:0] q0, q1, q2, q3, q4, q5, q6, q7;
   logic        intr;

   int nerr;
   int nchk;

   factorial_core #(.MUL_BITS(64)) dut (
      .clk     (clk),
      .reset   (reset),
      .s_sel   (s_sel),
      .s_wr    (s_wr),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .q0      (q0),
      .q1      (q1),
      .q2      (q2),
      .q3      (q3),
      .q4      (q4),
      .q5      (q5),
      .q6      (q6),
      .q7      (q7),
      .intr    (intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus write, taken on the next rising edge; returns 1 unit after that edge.
   task automatic bus_wr(input logic [2:0] addr, input logic [63:0] data);
      @(negedge clk);
      s_sel   = 1'b1;
      s_wr    = 1'b1;
      s_addr  = addr;
      s_wdata = data;
      @(posedge clk);
      #1;
      s_sel   = 1'b0;
      s_wr    = 1'b0;
      s_wdata = 64'd0;
   endtask

   task automatic wait_edges(input int n);
      for (int e = 0; e < n; e++) begin
         @(posedge clk);
      end
      #1;
   endtask

   // Load N and start; afterwards the start edge is edge 0.
   task automatic start_op(input logic [63:0] n);
      bus_wr(3'd3, n);
      bus_wr(3'd0, 64'd1);
   endtask

   // Confirms busy right up to edge L-1 and done exactly at edge L.
   task automatic wait_done(input string tag, input int lat, input logic [127:0] exp);
      if (lat > 1) wait_edges(lat - 1);
      check({tag, "_busy"}, q6, 2);
      wait_edges(1);
      check({tag, "_done"}, q6, 1);
      check({tag, "_res"}, {q4, q5}, exp);
   endtask

   initial begin
      nerr    = 0;
      nchk    = 0;
      reset   = 1'b1;
      s_sel   = 1'b0;
      s_wr    = 1'b0;
      s_addr  = 3'd0;
      s_wdata = 64'd0;
      wait_edges(3);
      @(negedge clk);
      reset = 1'b0;
      wait_edges(2);

      // Reset state
      check("rst_q0", q0, 0);
      check("rst_q1", q1, 0);
      check("rst_q2", q2, 0);
      check("rst_q3", q3, 0);
      check("rst_res", {q4, q5}, 0);
      check("rst_q6", q6, 0);
      check("rst_q7", q7, 0);
      check("rst_intr", intr, 0);

      // Register readback: only bit0 of INTR_EN sticks, reserved word ignores writes
      bus_wr(3'd2, 64'hFFFF_FFFF_FFFF_FFFF);
      check("inten_rd", q2, 1);
      bus_wr(3'd7, 64'h1234_5678_9ABC_DEF0);
      check("rsvd_rd", q7, 0);

      // 5! with interrupt enabled
      start_op(64'd5);
      check("n5_q0", q0, 0);
      check("n5_intr_busy", intr, 0);
      wait_done("n5", 261, 128'd120);
      check("n5_intr", intr, 1);
      check("n5_q3", q3, 5);

      // 0! and 1! complete one edge after the start, restarted from DONE
      start_op(64'd0);
      wait_done("n0", 1, 128'd1);
      start_op(64'd1);
      wait_done("n1", 1, 128'd1);
      check("n1_intr", intr, 1);

      // Dropping INTR_EN in DONE drops the interrupt
      bus_wr(3'd2, 64'd0);
      check("inten_off_intr", intr, 0);
      bus_wr(3'd2, 64'd1);
      check("inten_on_intr", intr, 1);

      // 25! spans both result words
      start_op(64'd25);
      wait_done("n25", 1561, {64'h0000_0000_000C_D4A0, 64'h619F_B090_7BC0_0000});

      // 20! with OPERAND and OPSTART writes while busy, both dropped
      start_op(64'd20);
      wait_edges(49);
      bus_wr(3'd3, 64'd7);
      bus_wr(3'd0, 64'd1);
      check("n20_opnd_kept", q3, 20);
      check("n20_mid_busy", q6, 2);
      wait_done("n20", 1236 - 51, {64'd0, 64'h21C3_677C_82B4_0000});

      // OPCLEAR at cycle 100 of a run
      start_op(64'd20);
      wait_edges(99);
      bus_wr(3'd1, 64'd1);
      check("clr_status", q6, 0);
      check("clr_res", {q4, q5}, 0);
      check("clr_intr", intr, 0);
      wait_edges(200);
      check("clr_stays_idle", q6, 0);

      // Reset during MUL, then 3!
      start_op(64'd5);
      wait_edges(10);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mrst_q2", q2, 0);
      check("mrst_q3", q3, 0);
      check("mrst_q6", q6, 0);
      check("mrst_res", {q4, q5}, 0);
      check("mrst_intr", intr, 0);
      @(negedge clk);
      reset = 1'b0;
      start_op(64'd3);
      wait_done("n3", 131, 128'd6);
      check("n3_intr", intr, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/factorial_core.md
Name: factorial_core

Overview:
- Memory-mapped factorial engine: a bus-writable register file plus an iterative sequential multiplier computing N! truncated to 128 bits.
- Sits directly upstream of the 64-bit 8-to-1 read-data mux. Its eight register outputs drive the mux inputs a..h in word-index order. The mux select is the bus word address.
- Raises an interrupt on completion when enabled.

Parameters:
- MUL_BITS, 64, multiplier operand width; cycles per multiply step (fixed at 64 in this design).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s_sel  in  1  block selected by bus decoder.
- s_wr  in  1  write strobe. A write occurs on an edge with s_sel=1 and s_wr=1.
- s_addr  in  3  register word index 0..7.
- s_wdata  in  64  write data.
- q0..q7  out  64 each  register values to mux inputs a..h.
- intr  out  1  interrupt, level.

Behaviour:
- Register map (word index, read value on qN):
  - 0 OPSTART: write bit0=1 starts. Self-clearing; always reads 0.
  - 1 OPCLEAR: write bit0=1 aborts and clears. Always reads 0.
  - 2 INTR_EN: bit0 read/write. Bits 63:1 read 0.
  - 3 OPERAND: N, 64-bit read/write.
  - 4 RESULT_H: bits 127:64 of the result.
  - 5 RESULT_L: bits 63:0 of the result.
  - 6 STATUS: bit0=opdone, bit1=busy. Other bits read 0. Read-only.
  - 7 reserved: reads 0, writes ignored.
- intr = opdone & INTR_EN[0], registered with the status bits.
- Reset: all q outputs = 0, intr = 0, FSM = IDLE.
- FSM states: IDLE, INIT, MUL, DEC, DONE.
- IDLE:
  - An OPSTART write with bit0=1 goes to INIT.
  - The result registers are cleared to 0 on this same edge.
  - busy=1 and opdone=0 from the next cycle.
- INIT (1 cycle):
  - acc <= 1, k <= N.
  - Next state is DONE if N < 2, else MUL.
- MUL (exactly 64 cycles, bit counter i = 0..63):
  - If k[i]=1, acc_next += acc << i.
  - All arithmetic is modulo 2^128; overflow bits are discarded.
- DEC (1 cycle):
  - acc <= product; k <= k-1.
  - Next state is MUL if k-1 >= 2, else DONE.
- DONE:
  - RESULT_H/RESULT_L <= acc; opdone=1, busy=0.
  - Remains here until an OPCLEAR write or a new start.
  - A new OPSTART write in DONE behaves as from IDLE and clears opdone.
- Latency from the edge sampling the OPSTART write to the edge setting opdone:
  - L = 1 for N < 2.
  - L = 1 + 65*(N-1) for N >= 2.
- Writes while busy:
  - Writes to OPSTART, OPERAND and INTR_EN are ignored.
  - OPCLEAR is always honoured.
- OPCLEAR write (any state): FSM -> IDLE, RESULT_H/L = 0, opdone = 0, busy = 0, intr = 0.
- Simultaneous events:
  - Reset wins over everything.
  - There is one write per cycle, so no address conflicts arise.
- Reset mid-operation: the computation is abandoned and all state returns to reset values on that edge.
- N >= 35: the result is the true value mod 2^128. Runtime can be very large; software bounds N.

Test Plan:
- Reset then idle: all q0..q7 = 0 and intr = 0 after reset deasserts.
- N=5, INTR_EN=1, start:
  - STATUS=2 while busy.
  - After exactly 261 edges: STATUS=1, RESULT_L=120, RESULT_H=0, intr=1.
- N=0 and N=1:
  - opdone after 1 edge.
  - RESULT_L=1, RESULT_H=0.
- N=25:
  - After 1561 edges: RESULT_H=0x00000000000CD4A0, RESULT_L=0x619FB0907BC00000.
  - N=20 gives RESULT_L=0x21C3677C82B40000 after 1236 edges.
- Write OPERAND=7 and OPSTART during an N=20 run:
  - Both are ignored; the final result equals 20!.
  - OPCLEAR at cycle 100 of a run: next cycle STATUS=0, results=0, intr=0.
- Assert reset during MUL: all outputs go to 0 next edge. A subsequent N=3 start yields 6 after 131 edges.
